// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI mode-0 slave with RX/TX FIFOs.
package spi_pkg;

  localparam int unsigned DefWordW = 8;
  localparam int unsigned DefDepth = 4;

  typedef enum logic {
    LsbFirst = 1'b0,
    MsbFirst = 1'b1
  } bit_order_e;

  typedef struct packed {
    logic overflow;
    logic underrun;
  } spi_status_t;

endpackage

// File: rtl/spi_fifo.sv
// Synchronous FIFO on the SPI clock; push when full and pop when empty are ignored.
module spi_fifo import spi_pkg::*; #(
  parameter int unsigned W     = DefWordW,
  parameter int unsigned DEPTH = DefDepth
) (
  input  logic                     sclk,
  input  logic                     rst_L,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  output logic                     full,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [W-1:0]    mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign full  = (count_q == (PtrW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

  // Next-state for pointers and occupancy; a full FIFO with push+pop only pops.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (do_push && !do_pop) begin
      count_d = count_q + (PtrW+1)'(1);
    end else if (!do_push && do_pop) begin
      count_d = count_q - (PtrW+1)'(1);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge sclk or negedge rst_L) begin
    if (!rst_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge sclk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/spi_slave_fifo.sv
// SPI mode-0 slave: word-framed shift in/out with RX and TX FIFOs and sticky error flags.
module spi_slave_fifo import spi_pkg::*; #(
  parameter int unsigned       WORD_W    = DefWordW,
  parameter int unsigned       DEPTH     = DefDepth,
  parameter bit                MSB_FIRST = 1'b1,
  parameter logic [WORD_W-1:0] FILL      = '0
) (
  input  logic                     sclk,
  input  logic                     rst_L,
  input  logic                     ss,
  input  logic                     mosi,
  output logic                     miso,
  input  logic [WORD_W-1:0]        tx_wdata,
  input  logic                     tx_push,
  output logic                     tx_full,
  output logic [$clog2(DEPTH):0]   tx_count,
  output logic [WORD_W-1:0]        rx_rdata,
  input  logic                     rx_pop,
  output logic                     rx_empty,
  output logic [$clog2(DEPTH):0]   rx_count,
  output logic                     overflow,
  output logic                     underrun,
  input  logic                     stat_clr
);

  localparam int unsigned     CntW    = $clog2(WORD_W);
  localparam bit_order_e      Order   = MSB_FIRST ? MsbFirst : LsbFirst;
  localparam logic [CntW-1:0] LastBit = CntW'(WORD_W - 1);

  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] rx_shift_q, rx_shift_d;
  logic [WORD_W-1:0] cur_tx_q, cur_tx_d;
  logic              miso_q, miso_d;
  spi_status_t       status_q, status_d;

  logic              word_start, word_end;
  logic [WORD_W-1:0] tx_rdata, head_word;
  logic              tx_empty, rx_full;
  logic [CntW-1:0]   tx_idx;

  // Bit counter, RX shifter, TX word latch and sticky flags for the posedge domain.
  always_comb begin
    word_start = ss && (bit_cnt_q == '0);
    word_end   = ss && (bit_cnt_q == LastBit);
    head_word  = tx_empty ? FILL : tx_rdata;

    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    if (!ss) begin
      // Deselect abandons any partial word.
      bit_cnt_d  = '0;
      rx_shift_d = '0;
    end else begin
      bit_cnt_d = word_end ? '0 : bit_cnt_q + CntW'(1);
      if (Order == MsbFirst) rx_shift_d = {rx_shift_q[WORD_W-2:0], mosi};
      else                   rx_shift_d = {mosi, rx_shift_q[WORD_W-1:1]};
    end

    cur_tx_d = word_start ? head_word : cur_tx_q;

    // Set wins over a simultaneous clear.
    status_d = stat_clr ? '0 : status_q;
    if (word_end && rx_full)    status_d.overflow = 1'b1;
    if (word_start && tx_empty) status_d.underrun = 1'b1;
  end

  // miso source: head word before the first posedge of a word, latched word afterwards.
  always_comb begin
    tx_idx = (Order == MsbFirst) ? (LastBit - bit_cnt_q) : bit_cnt_q;
    if (bit_cnt_q == '0) begin
      miso_d = (Order == MsbFirst) ? head_word[WORD_W-1] : head_word[0];
    end else begin
      miso_d = cur_tx_q[tx_idx];
    end
  end

  // Posedge state.
  always_ff @(posedge sclk or negedge rst_L) begin
    if (!rst_L) begin
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      cur_tx_q   <= '0;
      status_q   <= '0;
    end else begin
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      cur_tx_q   <= cur_tx_d;
      status_q   <= status_d;
    end
  end

  // miso changes on the falling edge so it is stable at the master's sampling edge.
  always_ff @(negedge sclk or negedge rst_L) begin
    if (!rst_L) miso_q <= 1'b0;
    else        miso_q <= miso_d;
  end

  assign miso     = miso_q;
  assign overflow = status_q.overflow;
  assign underrun = status_q.underrun;

  spi_fifo #(
    .W     (WORD_W),
    .DEPTH (DEPTH)
  ) u_rx_fifo (
    .sclk  (sclk),
    .rst_L (rst_L),
    .push  (word_end),
    .wdata (rx_shift_d),
    .full  (rx_full),
    .pop   (rx_pop),
    .rdata (rx_rdata),
    .empty (rx_empty),
    .count (rx_count)
  );

  spi_fifo #(
    .W     (WORD_W),
    .DEPTH (DEPTH)
  ) u_tx_fifo (
    .sclk  (sclk),
    .rst_L (rst_L),
    .push  (tx_push),
    .wdata (tx_wdata),
    .full  (tx_full),
    .pop   (word_start),
    .rdata (tx_rdata),
    .empty (tx_empty),
    .count (tx_count)
  );

endmodule

// File: tb/tb_spi_slave_fifo.sv
// Randomised and directed bench for spi_slave_fifo against a queue-based word model.
module tb_spi_slave_fifo;

  logic       sclk = 1'b0;
  logic       rst_L = 1'b0;

  // 8-bit MSB-first instance
  logic       ss = 1'b0, mosi = 1'b0, miso;
  logic [7:0] tx_wdata = '0, rx_rdata;
  logic       tx_push = 1'b0, tx_full, rx_pop = 1'b0, rx_empty;
  logic [2:0] tx_count, rx_count;
  logic       overflow, underrun, stat_clr = 1'b0;

  // 16-bit LSB-first instance
  logic        ss16 = 1'b0, mosi16 = 1'b0, miso16;
  logic [15:0] tx_wdata16 = '0, rx_rdata16;
  logic        tx_push16 = 1'b0, tx_full16, rx_pop16 = 1'b0, rx_empty16;
  logic [2:0]  tx_count16, rx_count16;
  logic        overflow16, underrun16;

  always #5 sclk = ~sclk;

  spi_slave_fifo #(
    .WORD_W(8), .DEPTH(4), .MSB_FIRST(1'b1), .FILL(8'h00)
  ) u_dut (
    .sclk(sclk), .rst_L(rst_L), .ss(ss), .mosi(mosi), .miso(miso),
    .tx_wdata(tx_wdata), .tx_push(tx_push), .tx_full(tx_full), .tx_count(tx_count),
    .rx_rdata(rx_rdata), .rx_pop(rx_pop), .rx_empty(rx_empty), .rx_count(rx_count),
    .overflow(overflow), .underrun(underrun), .stat_clr(stat_clr)
  );

  spi_slave_fifo #(
    .WORD_W(16), .DEPTH(4), .MSB_FIRST(1'b0), .FILL(16'h0000)
  ) u_dut16 (
    .sclk(sclk), .rst_L(rst_L), .ss(ss16), .mosi(mosi16), .miso(miso16),
    .tx_wdata(tx_wdata16), .tx_push(tx_push16), .tx_full(tx_full16), .tx_count(tx_count16),
    .rx_rdata(rx_rdata16), .rx_pop(rx_pop16), .rx_empty(rx_empty16), .rx_count(rx_count16),
    .overflow(overflow16), .underrun(underrun16), .stat_clr(1'b0)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Word-level model of the 8-bit instance
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  int         m_pos;   // bits already exchanged in the current word
  int         m_acc;   // received bits, MSB first
  logic [7:0] m_cur;   // word being transmitted
  logic       m_ovf, m_und;

  task automatic reset_model();
    tx_q.delete();
    rx_q.delete();
    m_pos = 0;
    m_acc = 0;
    m_cur = '0;
    m_ovf = 1'b0;
    m_und = 1'b0;
  endtask

  task automatic check_status();
    check_eq("tx_count", 32'(tx_count), 32'(tx_q.size()));
    check_eq("rx_count", 32'(rx_count), 32'(rx_q.size()));
    check_eq("tx_full", 32'(tx_full), 32'(tx_q.size() == 4));
    check_eq("rx_empty", 32'(rx_empty), 32'(rx_q.size() == 0));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
    check_eq("underrun", 32'(underrun), 32'(m_und));
    if (rx_q.size() != 0) check_eq("rx_rdata", 32'(rx_rdata), 32'(rx_q[0]));
  endtask

  // One sclk period on the 8-bit instance: check miso, drive, clock, update model, check.
  task automatic cycle(input logic i_ss, input logic i_mosi, input logic i_push,
                       input logic [7:0] i_wdata, input logic i_pop, input logic i_clr);
    logic [7:0] head, word;
    logic       exp_miso;
    int         pre_tx, pre_rx;
    bit         done;
    @(negedge sclk);
    #1;
    head     = (tx_q.size() != 0) ? tx_q[0] : 8'h00;
    exp_miso = (m_pos == 0) ? head[7] : m_cur[7 - m_pos];
    check_eq("miso", 32'(miso), 32'(exp_miso));
    ss = i_ss; mosi = i_mosi; tx_push = i_push; tx_wdata = i_wdata;
    rx_pop = i_pop; stat_clr = i_clr;
    @(posedge sclk);
    #1;
    tx_push = 1'b0; rx_pop = 1'b0; stat_clr = 1'b0;
    pre_tx = tx_q.size();
    pre_rx = rx_q.size();
    done   = 1'b0;
    word   = '0;
    if (i_clr) begin
      m_ovf = 1'b0;
      m_und = 1'b0;
    end
    if (i_ss) begin
      if (m_pos == 0) begin
        m_cur = (pre_tx != 0) ? tx_q[0] : 8'h00;
        if (pre_tx != 0) void'(tx_q.pop_front());
        else m_und = 1'b1;
      end
      m_acc = (m_acc * 2 + int'(i_mosi)) % 256;
      if (m_pos == 7) begin
        done = 1'b1;
        word = 8'(m_acc);
      end
      m_pos = (m_pos + 1) % 8;
    end else begin
      m_pos = 0;
      m_acc = 0;
    end
    if (i_pop && pre_rx != 0) void'(rx_q.pop_front());
    if (done) begin
      if (pre_rx < 4) rx_q.push_back(word);
      else m_ovf = 1'b1;
    end
    if (i_push && pre_tx < 4) tx_q.push_back(i_wdata);
    check_status();
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic frame(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) cycle(1'b1, w[i], 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic pop_rx();
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic cycle16(input logic i_ss, input logic i_mosi, input logic i_push,
                         input logic [15:0] i_wdata, input logic exp_miso);
    @(negedge sclk);
    #1;
    check_eq("miso16", 32'(miso16), 32'(exp_miso));
    ss16 = i_ss; mosi16 = i_mosi; tx_push16 = i_push; tx_wdata16 = i_wdata;
    @(posedge sclk);
    #1;
    tx_push16 = 1'b0;
  endtask

  initial begin
    logic [7:0]  burst [5];
    logic [7:0]  part;
    logic [15:0] tx16w, rx16w;
    logic        r_ss;

    reset_model();
    #3;
    check_eq("rst_miso", 32'(miso), 32'd0);
    check_eq("rst_tx_full", 32'(tx_full), 32'd0);
    check_eq("rst_rx_empty", 32'(rx_empty), 32'd1);
    check_eq("rst_tx_count", 32'(tx_count), 32'd0);
    check_eq("rst_rx_count", 32'(rx_count), 32'd0);
    check_eq("rst_flags", 32'({overflow, underrun}), 32'd0);
    rst_L = 1'b1;

    // Basic exchange: A5 out, 3C in
    cycle(1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
    frame(8'h3C);
    idle();
    check_eq("t1_rx_word", 32'(rx_rdata), 32'h3C);
    check_eq("t1_rx_count", 32'(rx_count), 32'd1);
    check_eq("t1_flags", 32'({overflow, underrun}), 32'd0);
    pop_rx();

    // Empty TX: FILL sent, underrun sticky until cleared
    frame(8'h5A);
    idle();
    idle();
    check_eq("t2_underrun", 32'(underrun), 32'd1);
    check_eq("t2_rx_word", 32'(rx_rdata), 32'h5A);
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check_eq("t2_underrun_clr", 32'(underrun), 32'd0);

    // Five-word burst without popping: fifth word dropped
    burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 5; i++) frame(burst[i]);
    idle();
    check_eq("t3_overflow", 32'(overflow), 32'd1);
    check_eq("t3_rx_count", 32'(rx_count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_eq("t3_order", 32'(rx_rdata), 32'(burst[i]));
      pop_rx();
    end
    cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Deselect after 5 bits, then a clean frame
    part = 8'hF0;
    for (int i = 7; i >= 3; i--) cycle(1'b1, part[i], 1'b0, 8'h00, 1'b0, 1'b0);
    idle();
    frame(8'h81);
    idle();
    check_eq("t4_rx_count", 32'(rx_count), 32'd1);
    check_eq("t4_rx_word", 32'(rx_rdata), 32'h81);
    pop_rx();

    // Push to empty TX on the word-start edge is not seen by that word
    part = 8'hC3;
    cycle(1'b1, part[7], 1'b1, 8'h77, 1'b0, 1'b1);
    for (int i = 6; i >= 0; i--) cycle(1'b1, part[i], 1'b0, 8'h00, 1'b0, 1'b0);
    check_eq("t5_underrun", 32'(underrun), 32'd1);
    check_eq("t5_tx_count", 32'(tx_count), 32'd1);
    frame(8'h00);
    idle();
    pop_rx();
    pop_rx();

    // Overfill TX: fifth push ignored, then drain
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b1, 8'(8'h90 + i), 1'b0, 1'b0);
    check_eq("t6_tx_full", 32'(tx_full), 32'd1);
    for (int i = 0; i < 4; i++) frame(8'(i));
    idle();
    for (int i = 0; i < 4; i++) pop_rx();

    // 16-bit LSB-first instance
    tx16w = 16'h8001;
    rx16w = 16'h1234;
    cycle16(1'b0, 1'b0, 1'b1, tx16w, 1'b0);
    for (int i = 0; i < 16; i++) cycle16(1'b1, rx16w[i], 1'b0, 16'h0000, tx16w[i]);
    cycle16(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    check_eq("t7_rx16", 32'(rx_rdata16), 32'h1234);
    check_eq("t7_rx16_count", 32'(rx_count16), 32'd1);
    check_eq("t7_tx16_count", 32'(tx_count16), 32'd0);
    check_eq("t7_flags16", 32'({overflow16, underrun16, tx_full16, rx_empty16}), 32'd0);

    // Reset mid-frame with both FIFOs populated
    cycle(1'b0, 1'b0, 1'b1, 8'hB1, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 8'hB2, 1'b0, 1'b0);
    frame(8'hAA);
    part = 8'h6D;
    for (int i = 7; i >= 4; i--) cycle(1'b1, part[i], 1'b0, 8'h00, 1'b0, 1'b0);
    #1;
    rst_L = 1'b0;
    ss = 1'b0;
    #1;
    check_eq("t8_tx_count", 32'(tx_count), 32'd0);
    check_eq("t8_rx_count", 32'(rx_count), 32'd0);
    check_eq("t8_miso", 32'(miso), 32'd0);
    check_eq("t8_flags", 32'({overflow, underrun}), 32'd0);
    rst_L = 1'b1;
    reset_model();
    cycle(1'b0, 1'b0, 1'b1, 8'h4E, 1'b0, 1'b0);
    frame(8'hE7);
    idle();
    check_eq("t8_rx_word", 32'(rx_rdata), 32'hE7);
    pop_rx();

    // Random traffic
    r_ss = 1'b0;
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(15) == 0) r_ss = ~r_ss;
      cycle(r_ss, 1'($urandom_range(1)), 1'($urandom_range(2) == 0), 8'($urandom),
            1'($urandom_range(3) == 0), 1'($urandom_range(19) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
